pipe_frame_assembler: RTL
=========================

// Module: pipe_frame_assembler
// PURPOSE
//  Parametrised successor to the fixed per-field instruction frame register. Assembles one pipeline frame from two
//  independently arriving halves and queues completed frames in a DEPTH-entry buffer:
//  - ctrl half: decoded fields (decode stage).
//  - opnd half: register operands (setup stage).
//  Sits between decode/setup and execute. Uses valid/ready handshakes and flush in place of state-gated latching.
// PARAMETERS
//  CTRL_WIDTH  64  width of decoded-control half
//  OPND_WIDTH  96  width of operand half (aOperand, bOperand, storeData)
//  DEPTH       2   completed-frame buffer entries; power of 2, >=2
//  CNT_WIDTH   16  width of statistics counters (PIPE_FRAME_STATS_EN only)
// PORTS
//  clk            in   1                clock
//  reset          in   1                reset, synchronous, active-high
//  flush          in   1                synchronous pipeline flush (branch/jump redirect)
//  ctrl_valid     in   1                ctrl half offered
//  ctrl_ready     out  1                ctrl half accepted when ctrl_valid&ctrl_ready
//  ctrl_in        in   CTRL_WIDTH       ctrl half data
//  opnd_valid     in   1                operand half offered
//  opnd_ready     out  1                operand half accepted when opnd_valid&opnd_ready
//  opnd_in        in   OPND_WIDTH       operand half data
//  out_valid      out  1                head frame available
//  out_ready      in   1                downstream consumes head when out_valid&out_ready
//  out_ctrl       out  CTRL_WIDTH       head frame ctrl half; 0 when !out_valid
//  out_opnd       out  OPND_WIDTH       head frame operand half; 0 when !out_valid
//  count          out  $clog2(DEPTH)+1  frames buffered
// BEHAVIOUR
//  - Reset: assembly flags, buffer pointers and count clear. Outputs after reset:
//    - out_valid=0; count=0; out_ctrl=0; out_opnd=0.
//    - ctrl_ready=1; opnd_ready=1; stats counters=0.
//  - Assembly register holds ctrl_have/opnd_have plus data. Readies are registered-only:
//    - ctrl_ready = !ctrl_have; opnd_ready = !opnd_have. No combinational path from out_ready.
//  - Halves may arrive in either order or in the same cycle. A second ctrl before the opnd stalls via ctrl_ready=0.
//  - Commit condition:
//    - complete = (ctrl_have | ctrl fire) & (opnd_have | opnd fire).
//    - space = (count<DEPTH) | (out_valid & out_ready).
//    - commit = complete & space & !flush.
//  - On commit, the frame (fresh inputs or held copy) is written to the buffer tail and both have-flags clear on that edge.
//  - Complete but no space: the frame stays in the assembly register with both flags set.
//  - Latency: last half accepted at edge N, out_valid=1 after edge N. Steady-state throughput is 1 frame/cycle when both
//    halves arrive together.
//  - Buffer: FIFO order. Simultaneous push and pop at count==DEPTH is legal and count is unchanged. Pop at count==0
//    is ignored. Pointers wrap modulo DEPTH.
//  - Flush has priority over every handshake:
//    - Clears the have-flags, pointers and count on that edge.
//    - Halves offered in the flush cycle are dropped; a pop in the flush cycle still counts as consumed.
//    - out_valid=0 in the following cycle.
//  - Reset has priority over flush. Reset mid-assembly discards the partial frame.
// CONFIGURATION
//  - PIPE_FRAME_STATS_EN defined:
//    - Adds outputs stall_cycles, frames_committed, flush_count, each CNT_WIDTH and saturating at all-ones.
//    - stall_cycles increments each cycle with out_valid & !out_ready.
//    - frames_committed increments on commit; flush_count increments on flush.
//    - All three are cleared by reset only.
//  - Undefined: counters and ports are absent; all other behaviour is identical.
// STRUCTURE
//  - pipe_frame_defs.vh (shared header, included beside globalVariables.v):
//    - Field offsets/widths packing decode fields into CTRL_WIDTH and operands into OPND_WIDTH.
//    - Default widths.
//  - Sub-module frame_fifo: synchronous DEPTH x (CTRL_WIDTH+OPND_WIDTH) FIFO with push/pop/count and sync clear
//    (used for flush).
//  - Top level holds the assembly register, commit logic and optional stats.
// TESTING
//  1. Reset with all inputs at 1 -> out_valid=0, count=0, ctrl_ready=opnd_ready=1, out_ctrl=0.
//  2. Same-cycle halves ctrl=0x11, opnd=0x22 on 4 consecutive cycles, out_ready=1 -> out_valid from the cycle after
//     the first push; 0x11/0x22 seen each cycle; count stays 1.
//  3. Opnd 0xA first, ctrl 0xB three cycles later -> opnd_ready=0 for those 3 cycles; frame appears 1 cycle after ctrl.
//  4. out_ready=0 for 3 frames (DEPTH=2) -> count=2; third frame held with readies 0. Raise out_ready -> order
//     1,2,3 preserved, no loss; stall_cycles = held cycles.
//  5. Push and pop at count=2 in the same cycle -> count stays 2; head advances.
//  6. Flush with count=2 and a half-assembled frame -> next cycle out_valid=0, count=0, both readies=1;
//     flush_count=1; a same-cycle offered half is not seen.

Source files
------------

// File: rtl/pipe_frame_assembler_pkg.sv
// pipe_frame_assembler_pkg: default widths and operand field layout shared by the frame assembler.
// Statistics counters are compiled in with PIPE_FRAME_STATS_EN.
package pipe_frame_assembler_pkg;

    localparam int CTRL_WIDTH_DEF = 64;
    localparam int OPND_WIDTH_DEF = 96;
    localparam int DEPTH_DEF      = 2;
    localparam int CNT_WIDTH_DEF  = 16;

    // Operand half layout, MSB first: aOperand, bOperand, storeData.
    typedef struct packed {
        logic [31:0] a_operand;
        logic [31:0] b_operand;
        logic [31:0] store_data;
    } opnd_t;

endpackage

// File: rtl/pipe_frame_assembler_fifo.sv
// pipe_frame_assembler_fifo: synchronous DEPTH-entry frame FIFO with push/pop/count and sync clear.
module pipe_frame_assembler_fifo #(
    parameter int WIDTH = 160,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         data_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty    = count == '0;
    assign full     = count == CW'(DEPTH);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/pipe_frame_assembler.sv
// pipe_frame_assembler: joins independently arriving ctrl/operand halves into frames and queues them.
// Define PIPE_FRAME_STATS_EN to add saturating stall/commit/flush counters.
module pipe_frame_assembler
    import pipe_frame_assembler_pkg::*;
#(
    parameter int CTRL_WIDTH = CTRL_WIDTH_DEF,
    parameter int OPND_WIDTH = OPND_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
`ifdef PIPE_FRAME_STATS_EN
    ,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    ctrl_valid,
    output logic                    ctrl_ready,
    input  logic [CTRL_WIDTH-1:0]   ctrl_in,
    input  logic                    opnd_valid,
    output logic                    opnd_ready,
    input  logic [OPND_WIDTH-1:0]   opnd_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CTRL_WIDTH-1:0]   out_ctrl,
    output logic [OPND_WIDTH-1:0]   out_opnd,
    output logic [$clog2(DEPTH):0]  count
`ifdef PIPE_FRAME_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]    stall_cycles,
    output logic [CNT_WIDTH-1:0]    frames_committed,
    output logic [CNT_WIDTH-1:0]    flush_count
`endif
);
    localparam int FW = CTRL_WIDTH + OPND_WIDTH;

    logic                  ctrl_have, opnd_have;
    logic [CTRL_WIDTH-1:0] ctrl_q;
    logic [OPND_WIDTH-1:0] opnd_q;
    logic                  ctrl_fire, opnd_fire, pop, full, empty, commit;
    logic [FW-1:0]         frame_in, head;

    assign ctrl_ready = !ctrl_have;
    assign opnd_ready = !opnd_have;
    assign ctrl_fire  = ctrl_valid && ctrl_ready;
    assign opnd_fire  = opnd_valid && opnd_ready;
    assign out_valid  = !empty;
    assign pop        = out_valid && out_ready;
    assign commit     = (ctrl_have || ctrl_fire) && (opnd_have || opnd_fire) && (!full || pop) && !flush;
    assign frame_in   = {ctrl_have ? ctrl_q : ctrl_in, opnd_have ? opnd_q : opnd_in};
    assign out_ctrl   = out_valid ? head[FW-1:OPND_WIDTH] : '0;
    assign out_opnd   = out_valid ? head[OPND_WIDTH-1:0] : '0;

    // A complete frame with no buffer space simply keeps both flags set until it commits.
    always_ff @(posedge clk) begin
        if (reset || flush || commit) begin
            ctrl_have <= 1'b0;
            opnd_have <= 1'b0;
        end else begin
            if (ctrl_fire) begin
                ctrl_have <= 1'b1;
                ctrl_q    <= ctrl_in;
            end
            if (opnd_fire) begin
                opnd_have <= 1'b1;
                opnd_q    <= opnd_in;
            end
        end
    end

    pipe_frame_assembler_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (flush),
        .push     (commit),
        .pop      (pop),
        .data_in  (frame_in),
        .data_out (head),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

`ifdef PIPE_FRAME_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles     <= '0;
            frames_committed <= '0;
            flush_count      <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_WIDTH'(1);
            if (commit && frames_committed != '1) frames_committed <= frames_committed + CNT_WIDTH'(1);
            if (flush && flush_count != '1) flush_count <= flush_count + CNT_WIDTH'(1);
        end
    end
`endif

endmodule
